uart_tx_arb: RTL
================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter: BUSY_WAIT, 4, max cycles in WAIT_HI for i_uart_busy to rise (range 1..255).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: i_req0_data  input  8  requester 0 byte.
REQ-005 SHALL have port: i_req0_valid  input  1  requester 0 byte pending.
REQ-006 SHALL have port: o_req0_ready  output  1  requester 0 byte accepted this cycle.
REQ-007 SHALL have ports i_req1_data, i_req1_valid and o_req1_ready, identical to REQ-004..006, for requester 1.
REQ-008 SHALL have port: o_uart_data  output  8  byte driven to the transmitter.
REQ-009 SHALL have port: o_uart_en  output  1  one-cycle start pulse to the transmitter.
REQ-010 SHALL have port: i_uart_busy  input  1  transmitter busy flag.
REQ-011 SHALL have port: o_grant  output  1  index of the most recently accepted requester.
REQ-012 SHALL have port: o_arb_busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port: o_drop  output  1  one-cycle pulse on busy-rise timeout.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT_HI, WAIT_LO.
REQ-015 SHALL set ready combinationally: o_reqN_ready = (state==IDLE) & !i_uart_busy & i_reqN_valid & (N is arbitration winner); at most one ready high per cycle.
REQ-016 SHALL, on an accept edge (valid & ready), register the winner's data into o_uart_data, set o_grant to the winner index, and go IDLE->ISSUE.
REQ-017 SHALL assert o_uart_en only in ISSUE, for exactly one cycle, then go ISSUE->WAIT_HI.
REQ-018 SHALL hold o_uart_data stable from ISSUE until the return to IDLE.
REQ-019 SHALL, in WAIT_HI, go to WAIT_LO on the first cycle i_uart_busy=1; if busy stays low for BUSY_WAIT cycles, go to IDLE and pulse o_drop for one cycle.
REQ-020 SHALL, in WAIT_LO, go to IDLE on the first cycle i_uart_busy=0.
REQ-021 SHALL arbitrate by round-robin (default build): with one valid, that requester wins; with both valid, the requester != o_grant wins.
REQ-022 SHALL give an accept-to-o_uart_en latency of exactly 1 cycle.
REQ-023 SHALL NOT accept while i_uart_busy=1 in IDLE, so an externally started transfer is never overlapped.
REQ-024 SHALL ignore i_reqN_valid changes outside IDLE; a requester holds data and valid until it sees ready.
REQ-025 SHALL count the WAIT_HI timeout with an 8-bit counter that clears on entry to WAIT_HI.

Reset
REQ-026 SHALL, while rst=1 (asynchronously), force state=IDLE, o_uart_data=8'h00, o_uart_en=0, o_grant=1 (so requester 0 wins first), o_drop=0, and the counter to 0.
REQ-027 SHALL keep o_reqN_ready=0 and o_arb_busy=0 during reset.
REQ-028 SHALL, on reset asserted mid-transfer (any non-IDLE state), abort immediately and drop the in-flight byte silently; o_drop is not pulsed.

Configuration
REQ-029 SHALL use macro UART_ARB_FIXED_PRIO_EN: when defined, requester 0 always wins a simultaneous request, o_grant still reports the winner, and REQ-021 round-robin is not built. When undefined, round-robin applies.

Verification
REQ-030 SHALL cover: req0 only, data 8'hA5, busy model rises 1 cycle after en and stays high 10 cycles -> ready0 one cycle, o_uart_en one cycle later with o_uart_data=8'hA5, IDLE reached after busy falls.
REQ-031 SHALL cover: both valid at reset release, data0=8'h11 and data1=8'h22, held -> order 11, 22, 11, 22; under UART_ARB_FIXED_PRIO_EN -> 11, 11, 11.
REQ-032 SHALL cover: transmitter model never raises busy -> o_drop pulses exactly BUSY_WAIT+1 cycles after o_uart_en, then the next request is accepted.
REQ-033 SHALL cover: i_uart_busy=1 while IDLE with req1 valid (8'h66) -> no ready until busy=0, then ready1 in that same cycle.
REQ-034 SHALL cover: rst pulsed during WAIT_LO -> o_uart_en=0 and o_uart_data=8'h00 without waiting for a clock edge; after release, req0 granted first.
REQ-035 SHALL cover: valid toggled during WAIT_HI/WAIT_LO -> no ready and no change on o_uart_data.

Source files
------------

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arb
// Brief    : Two-requester arbiter feeding a single UART transmitter; issues a
//            one-cycle start pulse and tracks the transmitter busy handshake.
//            Round-robin by default; define UART_ARB_FIXED_PRIO_EN for fixed
//            priority (requester 0 wins simultaneous requests).
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_arb #(
  parameter int BUSY_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_req0_data,
  input  logic       i_req0_valid,
  output logic       o_req0_ready,
  input  logic [7:0] i_req1_data,
  input  logic       i_req1_valid,
  output logic       o_req1_ready,
  output logic [7:0] o_uart_data,
  output logic       o_uart_en,
  input  logic       i_uart_busy,
  output logic       o_grant,
  output logic       o_arb_busy,
  output logic       o_drop
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam logic [7:0] C_TIMEOUT_LAST = 8'(BUSY_WAIT - 1);

  state_t     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       grant_q, grant_d;
  logic       drop_q, drop_d;
  logic [7:0] cnt_q, cnt_d;

  logic       w_win;
  logic       w_can_accept;
  logic       w_accept;

`ifdef UART_ARB_FIXED_PRIO_EN
  assign w_win = ~i_req0_valid;
`else
  // Both pending: the requester not served last time wins.
  assign w_win = (i_req0_valid & i_req1_valid) ? ~grant_q : i_req1_valid;
`endif

  assign w_can_accept = (state_q == IDLE) & ~i_uart_busy & ~rst;
  assign o_req0_ready = w_can_accept & i_req0_valid & ~w_win;
  assign o_req1_ready = w_can_accept & i_req1_valid & w_win;
  assign w_accept     = o_req0_ready | o_req1_ready;

  assign o_uart_data = data_q;
  assign o_uart_en   = (state_q == ISSUE);
  assign o_grant     = grant_q;
  assign o_arb_busy  = (state_q != IDLE);
  assign o_drop      = drop_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    grant_d = grant_q;
    drop_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          data_d  = w_win ? i_req1_data : i_req0_data;
          grant_d = w_win;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_HI;
        cnt_d   = 8'd0;
      end
      WAIT_HI: begin
        if (i_uart_busy) begin
          state_d = WAIT_LO;
        end else if (cnt_q == C_TIMEOUT_LAST) begin
          state_d = IDLE;
          drop_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_LO: begin
        if (!i_uart_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // grant resets to 1 so requester 0 wins the first contested round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= 8'h00;
      grant_q <= 1'b1;
      drop_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire
